// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

   // Default RAM address/data width; command words carry two extra opcode bits.
   localparam int ADDR_SIZE_DEF = 8;

   // Receive-path FSM states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   // Opcodes carried in rx_data[9:8]; passed to the RAM unchanged.
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_ctr.sv
// Serial-to-parallel shifter with bit counter for incoming command words.
// 'done' is a combinational strobe on the edge that samples the last bit;
// 'word' is the complete word including the bit being sampled.
module spi_shift_ctr #(
   parameter int WORD_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic              done,
   output logic [WORD_W-1:0] word
);

   localparam logic [3:0] LAST = 4'(WORD_W - 1);
   localparam logic [3:0] FULL = 4'(WORD_W);

   logic [3:0]        cnt;
   logic [WORD_W-1:0] sreg;
   logic              active;

   // Shifting stops once a full word has been taken; extra bits are ignored.
   assign active = en && (cnt < FULL);
   assign done   = active && (cnt == LAST);
   assign word   = {sreg[WORD_W-2:0], din};

   // Bit counter and shift register, cleared between frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (clr) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (active) begin
         cnt  <= cnt + 4'd1;
         sreg <= word;
      end
   end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit commands from MOSI into rx_data,
// and serialises RAM read data MSB-first onto MISO during READ_DATA frames.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int TXC_W = $clog2(ADDR_SIZE + 1);

   state_t               state;
   logic                 rd_addr_seen;
   logic                 done;
   logic [ADDR_SIZE+1:0] word;
   logic [ADDR_SIZE-1:0] tx_sh;
   logic [TXC_W-1:0]     tx_left;

   // Bits are taken from the CHK_CMD cycle onward; deasserting SS_n discards a partial word.
   spi_shift_ctr #(
      .WORD_W (ADDR_SIZE + 2)
   ) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (SS_n),
      .en    (!SS_n && (state != IDLE)),
      .din   (MOSI),
      .done  (done),
      .word  (word)
   );

   // Frame FSM with registered rx outputs and read-address tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:    state <= CHK_CMD;
               CHK_CMD: state <= !MOSI ? WRITE : (rd_addr_seen ? READ_DATA : READ_ADD);
               default: state <= state;
            endcase
         end
         if (done) begin
            rx_data  <= word;
            rx_valid <= 1'b1;
            if (state == READ_ADD)
               rd_addr_seen <= 1'b1;
            else if (state == READ_DATA)
               rd_addr_seen <= 1'b0;
         end
      end
   end

   // Reply shifter: load on tx_valid in READ_DATA, then drive MSB-first for ADDR_SIZE clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MISO    <= 1'b0;
         tx_sh   <= '0;
         tx_left <= '0;
      end else if (SS_n) begin
         MISO    <= 1'b0;
         tx_left <= '0;
      end else if (tx_left != '0) begin
         MISO    <= tx_sh[ADDR_SIZE-1];
         tx_sh   <= {tx_sh[ADDR_SIZE-2:0], 1'b0};
         tx_left <= tx_left - TXC_W'(1);
      end else begin
         MISO <= 1'b0;
         if ((state == READ_DATA) && tx_valid) begin
            tx_sh   <= tx_data;
            tx_left <= TXC_W'(ADDR_SIZE);
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if with an rx_data scoreboard.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int checks = 0;
   int errors = 0;
   logic [9:0] sb[$];

   spi_slave_if #(.ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rx_valid pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rx_valid !== 1'b0) begin
         if (sb.size() == 0)
            chk("rx_valid_unexpected", 32'(rx_valid), 32'd0);
         else
            chk("rx_data", 32'(rx_data), 32'(sb.pop_front()));
      end
   end

   // Full frame: SS_n low (cycle 0), ten bits MSB-first, then latency and width checks.
   task automatic frame(input logic [9:0] w, input bit expect_valid);
      @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         @(negedge clk); MOSI = w[i];
      end
      if (expect_valid) sb.push_back(w);
      @(negedge clk); chk("rx_valid_latency", 32'(rx_valid), 32'(expect_valid));
      @(negedge clk); chk("rx_valid_width", 32'(rx_valid), 32'd0);
   endtask

   task automatic end_frame();
      @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
      @(negedge clk);
   endtask

   // RAM reply pulse and the expected MISO sequence (all zero when ignored).
   task automatic reply(input logic [7:0] d, input bit shifts);
      @(negedge clk); tx_valid = 1'b1; tx_data = d;
      @(negedge clk); tx_valid = 1'b0; chk("miso_pre", 32'(MISO), 32'd0);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk); chk("miso_bit", 32'(MISO), shifts ? 32'(d[i]) : 32'd0);
      end
      @(negedge clk); chk("miso_post", 32'(MISO), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
      #2;
      chk("reset_rx_data", 32'(rx_data), 32'd0);
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_miso", 32'(MISO), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Write address, then extra bits in the same frame produce nothing.
      frame(10'h0A5, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); MOSI = ~MOSI;
         chk("extra_bits_no_valid", 32'(rx_valid), 32'd0);
      end
      end_frame();

      // Write data.
      frame(10'h13C, 1'b1);
      end_frame();

      // Read address, then read data with a C3 reply.
      frame(10'h207, 1'b1);
      end_frame();
      frame(10'h35A, 1'b1);
      reply(8'hC3, 1'b1);
      end_frame();

      // rd_addr_seen cleared: next MOSI=1 frame is a read address, reply ignored.
      frame(10'h3F0, 1'b1);
      reply(8'hFF, 1'b0);
      end_frame();

      // Now a read-data frame again; reply shifts.
      frame(10'h381, 1'b1);
      reply(8'h5A, 1'b1);
      end_frame();

      // Abort after six bits, then a clean frame.
      @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); MOSI = i[0];
      end
      @(negedge clk); SS_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("abort_no_valid", 32'(rx_valid), 32'd0);
      end
      frame(10'h066, 1'b1);
      end_frame();

      // Set up a read, start a reply, then reset asynchronously mid-shift.
      frame(10'h211, 1'b1);
      end_frame();
      frame(10'h322, 1'b1);
      @(negedge clk); tx_valid = 1'b1; tx_data = 8'hC3;
      @(negedge clk); tx_valid = 1'b0;
      @(negedge clk); chk("pre_reset_miso", 32'(MISO), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rx_data", 32'(rx_data), 32'd0);
      chk("async_rx_valid", 32'(rx_valid), 32'd0);
      chk("async_miso", 32'(MISO), 32'd0);
      @(negedge clk); rst_n = 1'b1; SS_n = 1'b1;
      @(negedge clk);

      // Reset cleared rd_addr_seen: MOSI=1 frame goes to READ_ADD, reply ignored.
      frame(10'h3C3, 1'b1);
      reply(8'hAA, 1'b0);
      end_frame();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
